// File: rtl/mode_ctrl.sv
// Burst-collecting producer for the mytypes::mode_t link: drives mode=start on a go
// request, sums BURST_LEN returned bytes, then drops back to mode=done.

package mytypes;
    typedef enum logic {
        start = 1'b0,
        done  = 1'b1
    } mode_t;
endpackage

module mode_ctrl
    import mytypes::*;
#(
    parameter  int BURST_LEN = 4,
    parameter  int TIMEOUT   = 15,
    localparam int SUM_W     = 8 + $clog2(BURST_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    output mode_t            mode,
    input  logic [7:0]       out,
    input  logic             out_valid,
    output logic             busy,
    output logic [SUM_W-1:0] sum,
    output logic             result_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FINISH
    } state_t;

    localparam logic [7:0] BEAT_LAST = 8'(BURST_LEN - 1);
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    state_t           r_state;
    mode_t            r_mode;
    logic             r_busy;
    logic [SUM_W-1:0] r_sum;
    logic             r_resultValid;
    logic             r_timeout;
    logic [7:0]       r_beatCnt;
    logic [7:0]       r_idleCnt;

    logic [SUM_W-1:0] w_beatExt;
    logic             w_lastBeat;
    logic             w_lastIdle;

    assign w_beatExt  = {{(SUM_W-8){1'b0}}, out};
    assign w_lastBeat = (r_beatCnt == BEAT_LAST);
    assign w_lastIdle = (r_idleCnt == IDLE_LAST);

    // The pulses default low each cycle so they last exactly the FINISH cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_mode        <= done;
            r_busy        <= 1'b0;
            r_sum         <= '0;
            r_resultValid <= 1'b0;
            r_timeout     <= 1'b0;
            r_beatCnt     <= '0;
            r_idleCnt     <= '0;
        end else begin
            r_resultValid <= 1'b0;
            r_timeout     <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_mode <= done;
                    r_busy <= 1'b0;
                    if (go) begin
                        r_sum     <= '0;
                        r_beatCnt <= '0;
                        r_idleCnt <= '0;
                        r_mode    <= start;
                        r_busy    <= 1'b1;
                        r_state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (out_valid) begin
                        r_sum     <= r_sum + w_beatExt;
                        r_beatCnt <= r_beatCnt + 8'd1;
                        r_idleCnt <= '0;
                        if (w_lastBeat) begin
                            r_state       <= FINISH;
                            r_mode        <= done;
                            r_resultValid <= 1'b1;
                        end
                    end else begin
                        r_idleCnt <= r_idleCnt + 8'd1;
                        if (w_lastIdle) begin
                            r_state   <= FINISH;
                            r_mode    <= done;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_mode  <= done;
                end
                default: begin
                    r_state <= IDLE;
                    r_mode  <= done;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mode         = r_mode;
    assign busy         = r_busy;
    assign sum          = r_sum;
    assign result_valid = r_resultValid;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_mode_ctrl.sv
// Directed self-checking bench for mode_ctrl with BURST_LEN=4, TIMEOUT=15 (SUM_W=11).

module tb_mode_ctrl;

    localparam int SUM_W = 11;
    localparam logic DONE  = 1'b1;
    localparam logic START = 1'b0;

    logic             clk;
    logic             rst;
    logic             go;
    mytypes::mode_t   mode;
    logic [7:0]       out;
    logic             out_valid;
    logic             busy;
    logic [SUM_W-1:0] sum;
    logic             result_valid;
    logic             timeout;

    int errors = 0;
    int checks = 0;

    // Observed bundle: {mode, busy, result_valid, timeout, sum}
    logic [14:0] obs;
    assign obs = {mode, busy, result_valid, timeout, sum};

    mode_ctrl #(.BURST_LEN(4), .TIMEOUT(15)) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .mode(mode),
        .out(out),
        .out_valid(out_valid),
        .busy(busy),
        .sum(sum),
        .result_valid(result_valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; out_valid = 1'b0; out = 8'd0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== {DONE, 1'b0, 1'b0, 1'b0, 11'd0}) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got mode/busy/rv/to/sum=%b expected %b", i, obs, {DONE, 1'b0, 1'b0, 1'b0, 11'd0});
            end
        end
    endtask

    task automatic test_normal();
        logic [10:0] expSum = 0;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_valid = 1'b1;
            out = 8'(10 * (i + 1));
            checks++;
            if (obs !== {START, 1'b1, 1'b0, 1'b0, expSum}) begin
                errors++;
                $display("[TB] FAIL normal_collect beat %0d: got %b expected %b", i, obs, {START, 1'b1, 1'b0, 1'b0, expSum});
            end
            tick();
            expSum = expSum + 11'(10 * (i + 1));
        end
        out_valid = 1'b0;
        checks++;
        if (obs !== {DONE, 1'b1, 1'b1, 1'b0, 11'd100}) begin
            errors++;
            $display("[TB] FAIL normal_finish: got %b expected %b", obs, {DONE, 1'b1, 1'b1, 1'b0, 11'd100});
        end
        tick();
        checks++;
        if (obs !== {DONE, 1'b0, 1'b0, 1'b0, 11'd100}) begin
            errors++;
            $display("[TB] FAIL normal_hold: got %b expected %b", obs, {DONE, 1'b0, 1'b0, 1'b0, 11'd100});
        end
    endtask

    task automatic test_gapped();
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int b = 0; b < 4; b++) begin
            out_valid = 1'b0;
            for (int g = 0; g < 3; g++) begin
                tick();
                checks++;
                if (obs !== {START, 1'b1, 1'b0, 1'b0, 11'(255 * b)}) begin
                    errors++;
                    $display("[TB] FAIL gapped_wait b%0d g%0d: got %b expected %b", b, g, obs, {START, 1'b1, 1'b0, 1'b0, 11'(255 * b)});
                end
            end
            out_valid = 1'b1;
            out = 8'd255;
            tick();
        end
        out_valid = 1'b0;
        checks++;
        if (obs !== {DONE, 1'b1, 1'b1, 1'b0, 11'd1020}) begin
            errors++;
            $display("[TB] FAIL gapped_finish: got %b expected %b", obs, {DONE, 1'b1, 1'b1, 1'b0, 11'd1020});
        end
        tick();
    endtask

    task automatic test_timeout();
        go = 1'b1;
        tick();
        go = 1'b0;
        out_valid = 1'b1; out = 8'd5; tick();
        out = 8'd7; tick();
        out_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            checks++;
            if (obs !== {START, 1'b1, 1'b0, 1'b0, 11'd12}) begin
                errors++;
                $display("[TB] FAIL timeout_wait idle %0d: got %b expected %b", k, obs, {START, 1'b1, 1'b0, 1'b0, 11'd12});
            end
        end
        tick();
        checks++;
        if (obs !== {DONE, 1'b1, 1'b0, 1'b1, 11'd12}) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: got %b expected %b", obs, {DONE, 1'b1, 1'b0, 1'b1, 11'd12});
        end
        tick();
        checks++;
        if (obs !== {DONE, 1'b0, 1'b0, 1'b0, 11'd12}) begin
            errors++;
            $display("[TB] FAIL timeout_after: got %b expected %b", obs, {DONE, 1'b0, 1'b0, 1'b0, 11'd12});
        end
    endtask

    task automatic test_back_to_back();
        go = 1'b1;
        tick();
        go = 1'b0;
        out_valid = 1'b1; out = 8'd1; tick();
        go = 1'b1; out = 8'd2; tick();
        go = 1'b0;
        checks++;
        if (obs !== {START, 1'b1, 1'b0, 1'b0, 11'd3}) begin
            errors++;
            $display("[TB] FAIL busy_go_collect: got %b expected %b", obs, {START, 1'b1, 1'b0, 1'b0, 11'd3});
        end
        out = 8'd3; tick();
        out = 8'd4; tick();
        out_valid = 1'b0;
        checks++;
        if (obs !== {DONE, 1'b1, 1'b1, 1'b0, 11'd10}) begin
            errors++;
            $display("[TB] FAIL busy_go_finish: got %b expected %b", obs, {DONE, 1'b1, 1'b1, 1'b0, 11'd10});
        end
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        checks++;
        if (obs !== {DONE, 1'b0, 1'b0, 1'b0, 11'd10}) begin
            errors++;
            $display("[TB] FAIL busy_go_dropped: got %b expected %b", obs, {DONE, 1'b0, 1'b0, 1'b0, 11'd10});
        end
        go = 1'b1;
        tick();
        checks++;
        if (obs !== {START, 1'b1, 1'b0, 1'b0, 11'd0}) begin
            errors++;
            $display("[TB] FAIL held_go_start: got %b expected %b", obs, {START, 1'b1, 1'b0, 1'b0, 11'd0});
        end
        out_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            out = 8'(i);
            tick();
        end
        out_valid = 1'b0;
        checks++;
        if (obs !== {DONE, 1'b1, 1'b1, 1'b0, 11'd10}) begin
            errors++;
            $display("[TB] FAIL held_go_finish: got %b expected %b", obs, {DONE, 1'b1, 1'b1, 1'b0, 11'd10});
        end
        tick();
        checks++;
        if (obs !== {DONE, 1'b0, 1'b0, 1'b0, 11'd10}) begin
            errors++;
            $display("[TB] FAIL held_go_idle_gap: got %b expected %b", obs, {DONE, 1'b0, 1'b0, 1'b0, 11'd10});
        end
        tick();
        go = 1'b0;
        checks++;
        if (obs !== {START, 1'b1, 1'b0, 1'b0, 11'd0}) begin
            errors++;
            $display("[TB] FAIL held_go_restart: got %b expected %b", obs, {START, 1'b1, 1'b0, 1'b0, 11'd0});
        end
        out_valid = 1'b1; out = 8'd1;
        for (int i = 0; i < 4; i++) tick();
        out_valid = 1'b0;
        checks++;
        if (obs !== {DONE, 1'b1, 1'b1, 1'b0, 11'd4}) begin
            errors++;
            $display("[TB] FAIL held_go_second_job: got %b expected %b", obs, {DONE, 1'b1, 1'b1, 1'b0, 11'd4});
        end
        tick();
    endtask

    task automatic test_reset_mid_job();
        go = 1'b1;
        tick();
        go = 1'b0;
        out_valid = 1'b1; out = 8'd10; tick();
        out = 8'd20; tick();
        out_valid = 1'b0;
        checks++;
        if (obs !== {START, 1'b1, 1'b0, 1'b0, 11'd30}) begin
            errors++;
            $display("[TB] FAIL midjob_before_rst: got %b expected %b", obs, {START, 1'b1, 1'b0, 1'b0, 11'd30});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== {DONE, 1'b0, 1'b0, 1'b0, 11'd0}) begin
            errors++;
            $display("[TB] FAIL midjob_async_rst: got %b expected %b", obs, {DONE, 1'b0, 1'b0, 1'b0, 11'd0});
        end
        tick();
        rst = 1'b0;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        out_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            out = 8'(10 * i);
            tick();
        end
        out_valid = 1'b0;
        checks++;
        if (obs !== {DONE, 1'b1, 1'b1, 1'b0, 11'd100}) begin
            errors++;
            $display("[TB] FAIL midjob_clean_rerun: got %b expected %b", obs, {DONE, 1'b1, 1'b1, 1'b0, 11'd100});
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        go = 1'b0;
        out = 8'd0;
        out_valid = 1'b0;
        test_reset();
        test_normal();
        test_gapped();
        test_timeout();
        test_back_to_back();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
